kalman_frame_rx: RTL and testbench

// Receive-side counterpart of the attitude telemetry UART link: deserialises 8N1 bytes on one RX pin and parses

---
 rtl/kalman_pkg.sv | 31 +++
 rtl/uart_rx.sv | 111 +++++++++++
 rtl/kalman_frame_rx.sv | 127 ++++++++++++
 tb/tb_kalman_frame_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// Shared constants and types for the attitude telemetry UART link.
// The TX-side frame builder imports the same header bytes and frame state encoding.
package kalman_pkg;

  localparam int unsigned UART_BITS   = 8;
  localparam int unsigned FRAME_LEN   = 8;
  localparam int unsigned PAYLOAD_LEN = FRAME_LEN - 2;

  localparam logic [7:0] HDR0 = 8'hDE;
  localparam logic [7:0] HDR1 = 8'hAD;

  typedef enum logic [1:0] {
    F_HDR0    = 2'd0,
    F_HDR1    = 2'd1,
    F_PAYLOAD = 2'd2
  } frame_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic signed [15:0] roll;
    logic signed [15:0] pitch;
    logic signed [15:0] yaw;
  } attitude_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, falling-edge start detect and
// mid-bit sampling. Emits one-cycle byte_valid or byte_ferr per received byte.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 1041
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_ferr
);
  import kalman_pkg::*;

  localparam int unsigned CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned HALF = BAUD_DIV / 2;
  localparam int unsigned BW   = $clog2(UART_BITS);

  logic rx_meta, rx_sync, rx_prev;

  rx_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [UART_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]          data_d;
  logic                bv_d, bf_d;

  // Synchroniser and edge-detect history preset to line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      data       <= data_d;
      byte_valid <= bv_d;
      byte_ferr  <= bf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data;
    bv_d    = 1'b0;
    bf_d    = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        // A line parked low never starts a byte: only a 1->0 transition does.
        if (rx_prev && !rx_sync) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_sync, shreg_q[UART_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BW'(UART_BITS - 1)) state_d = R_STOP;
        end
      end
      R_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BAUD_DIV - 1)) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (rx_sync) begin
            bv_d   = 1'b1;
            data_d = shreg_q;
          end else begin
            bf_d = 1'b1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: rtl/kalman_frame_rx.sv
// Attitude telemetry frame receiver: parses DE AD + six payload bytes and
// publishes roll/pitch/yaw atomically on each complete, uninterrupted frame.
module kalman_frame_rx #(
  parameter int unsigned CLK_FREQ       = 10000000,
  parameter int unsigned BAUD_DIV       = CLK_FREQ / 9600,
  parameter logic [7:0]  HDR0           = kalman_pkg::HDR0,
  parameter logic [7:0]  HDR1           = kalman_pkg::HDR1,
  parameter int unsigned TIMEOUT_CYCLES = 4 * 10 * BAUD_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic signed [15:0] roll,
  output logic signed [15:0] pitch,
  output logic signed [15:0] yaw,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [7:0]         frame_cnt,
  output logic [7:0]         err_cnt
);
  import kalman_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = 8 * (PAYLOAD_LEN - 1);
  localparam int unsigned IW = 3;

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (rx_data),
    .byte_valid (rx_valid),
    .byte_ferr  (rx_ferr)
  );

  frame_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] shadow_q, shadow_d;
  logic [TW-1:0] timer_q, timer_d;
  attitude_t     att_q, att_d;
  logic          fv_d, fe_d;
  logic [7:0]    fcnt_d, ecnt_d;
  logic          timeout, abort;

  assign roll  = att_q.roll;
  assign pitch = att_q.pitch;
  assign yaw   = att_q.yaw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= F_HDR0;
      idx_q       <= '0;
      shadow_q    <= '0;
      timer_q     <= '0;
      att_q       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      timer_q     <= timer_d;
      att_q       <= att_d;
      frame_valid <= fv_d;
      frame_err   <= fe_d;
      frame_cnt   <= fcnt_d;
      err_cnt     <= ecnt_d;
    end
  end

  // Idle timer only runs mid-frame; a byte arriving on the timeout cycle wins.
  assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign abort   = (state_q != F_HDR0) && (rx_ferr || timeout);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    att_d    = att_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    fcnt_d   = frame_cnt;
    ecnt_d   = err_cnt;
    timer_d  = '0;
    if (state_q != F_HDR0 && !rx_valid) timer_d = timer_q + TW'(1);

    if (rx_valid) begin
      unique case (state_q)
        F_HDR0: begin
          if (rx_data == HDR0) state_d = F_HDR1;
        end
        F_HDR1: begin
          if (rx_data == HDR1) begin
            state_d = F_PAYLOAD;
            idx_d   = '0;
          end else if (rx_data != HDR0) begin
            state_d = F_HDR0;
          end
        end
        F_PAYLOAD: begin
          if (idx_q == IW'(PAYLOAD_LEN - 1)) begin
            att_d.roll  = shadow_q[SW-1 -: 16];
            att_d.pitch = shadow_q[SW-17 -: 16];
            att_d.yaw   = {shadow_q[7:0], rx_data};
            fv_d        = 1'b1;
            fcnt_d      = frame_cnt + 8'd1;
            state_d     = F_HDR0;
          end else begin
            shadow_d = {shadow_q[SW-9:0], rx_data};
            idx_d    = idx_q + IW'(1);
          end
        end
        default: state_d = F_HDR0;
      endcase
    end else if (abort) begin
      state_d = F_HDR0;
      fe_d    = 1'b1;
      if (err_cnt != 8'hFF) ecnt_d = err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_kalman_frame_rx.sv
// Directed bench for kalman_frame_rx: good frames, header resync, timeout and
// framing aborts, line glitches, frame counter wrap and mid-frame reset.
module tb_kalman_frame_rx;

  // 4-cycle bits keep the 256-frame wrap run short.
  localparam int unsigned BD  = 4;
  localparam int unsigned TMO = 400;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               rx  = 1'b1;
  logic signed [15:0] roll, pitch, yaw;
  logic               frame_valid, frame_err;
  logic [7:0]         frame_cnt, err_cnt;

  int pass_n  = 0;
  int total_n = 0;
  int fv_n    = 0;
  int fe_n    = 0;

  kalman_frame_rx #(
    .CLK_FREQ       (10000000),
    .BAUD_DIV       (BD),
    .HDR0           (8'hDE),
    .HDR1           (8'hAD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .roll        (roll),
    .pitch       (pitch),
    .yaw         (yaw),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_n++;
    if (frame_err)   fe_n++;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] r, input logic [15:0] p, input logic [15:0] y);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(r[15:8], 1'b1);
    send_byte(r[7:0], 1'b1);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
    send_byte(y[15:8], 1'b1);
    send_byte(y[7:0], 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_n++;
    if ({roll, pitch, yaw} !== 48'h0) $display("FAIL reset_att got %h exp 0", {roll, pitch, yaw});
    else pass_n++;
    total_n++;
    if ({frame_valid, frame_err, frame_cnt, err_cnt} !== 18'h0)
      $display("FAIL reset_flags got %h exp 0", {frame_valid, frame_err, frame_cnt, err_cnt});
    else pass_n++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int fv0, fe0;
    fv0 = fv_n; fe0 = fe_n;
    send_frame(16'h1234, 16'hFF80, 16'h0005);
    idle(6);
    total_n++;
    if (fv_n - fv0 !== 1) $display("FAIL basic_fv got %0d exp 1", fv_n - fv0); else pass_n++;
    total_n++;
    if (roll !== 16'sh1234) $display("FAIL basic_roll got %h exp 1234", roll); else pass_n++;
    total_n++;
    if (pitch !== -16'sd128) $display("FAIL basic_pitch got %0d exp -128", pitch); else pass_n++;
    total_n++;
    if (yaw !== 16'sd5) $display("FAIL basic_yaw got %0d exp 5", yaw); else pass_n++;
    total_n++;
    if (frame_cnt !== 8'd1 || fe_n != fe0)
      $display("FAIL basic_cnt got cnt=%0d errs=%0d exp cnt=1 errs=0", frame_cnt, fe_n - fe0);
    else pass_n++;
  endtask

  task automatic test_resync();
    int fe0;
    fe0 = fe_n;
    send_byte(8'hDE, 1'b1);
    send_frame(16'h0001, 16'h0002, 16'h0003);
    idle(6);
    total_n++;
    if ({roll, pitch, yaw} !== {16'h0001, 16'h0002, 16'h0003})
      $display("FAIL resync_att got %h exp 000100020003", {roll, pitch, yaw});
    else pass_n++;
    total_n++;
    if (frame_cnt !== 8'd2 || fe_n != fe0)
      $display("FAIL resync_cnt got cnt=%0d errs=%0d exp cnt=2 errs=0", frame_cnt, fe_n - fe0);
    else pass_n++;
    // DE then a non-header byte falls back quietly; header bytes in payload are data
    send_byte(8'hDE, 1'b1);
    send_byte(8'h55, 1'b1);
    send_frame(16'hDEAD, 16'hDEAD, 16'h00DE);
    idle(6);
    total_n++;
    if ({roll, pitch, yaw} !== {16'hDEAD, 16'hDEAD, 16'h00DE})
      $display("FAIL payload_hdr got %h exp DEADDEAD00DE", {roll, pitch, yaw});
    else pass_n++;
    total_n++;
    if (frame_cnt !== 8'd3 || fe_n != fe0)
      $display("FAIL payload_cnt got cnt=%0d errs=%0d exp cnt=3 errs=0", frame_cnt, fe_n - fe0);
    else pass_n++;
  endtask

  task automatic test_timeout();
    int fv0, fe0;
    fv0 = fv_n; fe0 = fe_n;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(TMO - 20);
    total_n++;
    if (fe_n != fe0) $display("FAIL timeout_early got %0d exp 0", fe_n - fe0); else pass_n++;
    idle(40);
    total_n++;
    if (fe_n - fe0 !== 1 || err_cnt !== 8'd1)
      $display("FAIL timeout_err got pulses=%0d cnt=%0d exp 1/1", fe_n - fe0, err_cnt);
    else pass_n++;
    total_n++;
    if ({roll, pitch, yaw} !== {16'hDEAD, 16'hDEAD, 16'h00DE} || fv_n != fv0)
      $display("FAIL timeout_hold got %h fv=%0d exp DEADDEAD00DE fv=0", {roll, pitch, yaw}, fv_n - fv0);
    else pass_n++;
  endtask

  task automatic test_ferr();
    int fe0;
    apply_reset();
    fe0 = fe_n;
    send_byte(8'h33, 1'b0);
    idle(BD * 2);
    total_n++;
    if (fe_n != fe0 || err_cnt !== 8'd0)
      $display("FAIL ferr_hdr0 got pulses=%0d cnt=%0d exp 0/0", fe_n - fe0, err_cnt);
    else pass_n++;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(BD * 2);
    total_n++;
    if (fe_n - fe0 !== 1 || err_cnt !== 8'd1)
      $display("FAIL ferr_abort got pulses=%0d cnt=%0d exp 1/1", fe_n - fe0, err_cnt);
    else pass_n++;
    total_n++;
    if ({roll, pitch, yaw} !== 48'h0) $display("FAIL ferr_hold got %h exp 0", {roll, pitch, yaw});
    else pass_n++;
    send_frame(16'h0A0B, 16'h0C0D, 16'h0E0F);
    idle(6);
    total_n++;
    if ({roll, pitch, yaw} !== {16'h0A0B, 16'h0C0D, 16'h0E0F} || frame_cnt !== 8'd1)
      $display("FAIL ferr_recover got %h cnt=%0d exp 0A0B0C0D0E0F cnt=1", {roll, pitch, yaw}, frame_cnt);
    else pass_n++;
  endtask

  task automatic test_glitch();
    int fv0, fe0;
    fv0 = fv_n; fe0 = fe_n;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(BD * 2);
    rx = 1'b0;
    @(negedge clk);
    idle(BD * 3);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    idle(6);
    total_n++;
    if ({roll, pitch, yaw} !== {16'h0102, 16'h0304, 16'h0506})
      $display("FAIL glitch_att got %h exp 010203040506", {roll, pitch, yaw});
    else pass_n++;
    total_n++;
    if (fv_n - fv0 !== 1 || fe_n != fe0)
      $display("FAIL glitch_pulses got fv=%0d fe=%0d exp 1/0", fv_n - fv0, fe_n - fe0);
    else pass_n++;
  endtask

  task automatic test_wrap_and_reset();
    int fv0;
    logic [15:0] v;
    apply_reset();
    fv0 = fv_n;
    for (int i = 0; i < 256; i++) begin
      v = 16'(i);
      send_frame(v, ~v, v ^ 16'h5A5A);
    end
    idle(6);
    total_n++;
    if (fv_n - fv0 !== 256 || frame_cnt !== 8'd0)
      $display("FAIL wrap_cnt got fv=%0d cnt=%0d exp 256/0", fv_n - fv0, frame_cnt);
    else pass_n++;
    total_n++;
    if ({roll, pitch, yaw} !== {16'h00FF, 16'hFF00, 16'h5AA5} || err_cnt !== 8'd0)
      $display("FAIL wrap_att got %h err=%0d exp 00FFFF005AA5 err=0", {roll, pitch, yaw}, err_cnt);
    else pass_n++;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'h12, 1'b1);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    rst = 1'b1;
    #1;
    total_n++;
    if ({roll, pitch, yaw, frame_cnt, err_cnt, frame_valid, frame_err} !== 66'h0)
      $display("FAIL midreset_clear got %h exp 0", {roll, pitch, yaw, frame_cnt, err_cnt, frame_valid, frame_err});
    else pass_n++;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(BD * 2);
    send_frame(16'h7FFF, 16'h8000, 16'hABCD);
    idle(6);
    total_n++;
    if ({roll, pitch, yaw} !== {16'h7FFF, 16'h8000, 16'hABCD} || frame_cnt !== 8'd1)
      $display("FAIL midreset_next got %h cnt=%0d exp 7FFF8000ABCD cnt=1", {roll, pitch, yaw}, frame_cnt);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_resync();
    test_timeout();
    test_ferr();
    test_glitch();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
